pc_fetch_ctrl: RTL and testbench

Instruction-fetch and branch-control sequencer driving the program-counter block. Each instruction is fetched at the current PC through a req/ack instruction-memory handshake, then decoded. The block then issues one execute cycle in which it drives the PC control strobes (BRANCH, JMP, flag_Rd_PC, flag_label_PC, flag_Rm_PC), the offsets (disp8, label11) and the register targets (Rd, Rm). It is the producer side of the PC block's control interface and sits between instruction memory, register file, status flags and the PC block.

---
 rtl/pc_fetch_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//
// Instruction-fetch and branch-control sequencer for the program-counter
// block. Each instruction passes through FETCH (req/ack handshake on the
// instruction memory), DECODE (classify the word and sample flags/register
// data) and EXEC (one cycle of pc_en with the PC control strobes). The word
// 16'hFFFF parks the sequencer in HALT until the next reset.
//
// Ports:
//   clk, clr_n             clock, asynchronous active-low reset
//   pc                     current PC from the PC block (fetch address)
//   imem_req/imem_addr     fetch request and address (address valid in FETCH)
//   imem_rdata/imem_ack    fetched word and completion strobe
//   flag_z/n/c/v           status flags, sampled at the end of DECODE
//   rd_idx/rm_idx          register-file read indices for register jumps
//   rd_data/rm_data        register-file read data, sampled at end of DECODE
//   pc_en                  PC advance/load enable (EXEC only)
//   BRANCH, JMP            branch / jump select toward the PC block
//   flag_Rd_PC, flag_label_PC, flag_Rm_PC   jump target source select
//   disp8, label11         branch displacement and jump label
//   Rd, Rm                 register jump targets
//   halted                 high while parked in HALT
//   retired                count of instructions that completed EXEC
// ---------------------------------------------------------------------------
module pc_fetch_ctrl (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [15:0] pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        flag_c,
    input  logic        flag_v,
    output logic [3:0]  rd_idx,
    output logic [3:0]  rm_idx,
    input  logic [15:0] rd_data,
    input  logic [15:0] rm_data,
    output logic        pc_en,
    output logic        BRANCH,
    output logic        JMP,
    output logic        flag_Rd_PC,
    output logic        flag_label_PC,
    output logic        flag_Rm_PC,
    output logic [7:0]  disp8,
    output logic [10:0] label11,
    output logic [15:0] Rd,
    output logic [15:0] Rm,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        HALT
    } state_t;

    state_t      state;
    logic [15:0] ir;

    logic is_branch;
    logic is_jmp_label;
    logic is_jmp_rm;
    logic is_jmp_rd;
    logic is_halt;
    logic cond_taken;

    // Instruction classification and branch condition evaluation from IR.
    // Only meaningful in DECODE, where the result is registered for EXEC.
    always_comb begin
        is_branch    = (ir[15:12] == 4'b1101);
        is_jmp_label = (ir[15:11] == 5'b11100);
        is_jmp_rm    = (ir[15:7] == 9'b010001110);
        is_jmp_rd    = (ir[15:7] == 9'b010001111);
        is_halt      = (ir == 16'hFFFF);
        cond_taken   = 1'b0;
        case (ir[11:8])
            4'h0:    cond_taken = flag_z;
            4'h1:    cond_taken = !flag_z;
            4'h2:    cond_taken = flag_c;
            4'h3:    cond_taken = !flag_c;
            4'h4:    cond_taken = flag_n;
            4'h5:    cond_taken = !flag_n;
            4'h6:    cond_taken = flag_v;
            4'h7:    cond_taken = !flag_v;
            4'hE:    cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase
    end

    // The fetch address follows pc directly: the PC block loads on the edge
    // that ends EXEC, so a registered copy would present the stale PC.
    assign imem_req  = (state == FETCH);
    assign imem_addr = imem_req ? pc : 16'h0000;

    // Register indices are presented during DECODE so the register file's
    // read data is ready when the DECODE->EXEC edge samples it.
    assign rd_idx = (state == DECODE && is_jmp_rd) ? ir[6:3] : 4'h0;
    assign rm_idx = (state == DECODE && is_jmp_rm) ? ir[6:3] : 4'h0;

    // Sequencer with registered EXEC outputs. Everything EXEC drives is
    // captured at the DECODE->EXEC edge and cleared at the EXEC->FETCH edge,
    // so late changes of flags or register data cannot disturb EXEC.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state         <= IDLE;
            ir            <= 16'h0000;
            pc_en         <= 1'b0;
            BRANCH        <= 1'b0;
            JMP           <= 1'b0;
            flag_Rd_PC    <= 1'b0;
            flag_label_PC <= 1'b0;
            flag_Rm_PC    <= 1'b0;
            disp8         <= 8'h00;
            label11       <= 11'h000;
            Rd            <= 16'h0000;
            Rm            <= 16'h0000;
            halted        <= 1'b0;
            retired       <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_halt) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        pc_en         <= 1'b1;
                        BRANCH        <= is_branch && cond_taken;
                        disp8         <= (is_branch && cond_taken) ? ir[7:0] : 8'h00;
                        JMP           <= is_jmp_label || is_jmp_rm || is_jmp_rd;
                        flag_label_PC <= is_jmp_label;
                        label11       <= is_jmp_label ? ir[10:0] : 11'h000;
                        flag_Rm_PC    <= is_jmp_rm;
                        Rm            <= is_jmp_rm ? rm_data : 16'h0000;
                        flag_Rd_PC    <= is_jmp_rd;
                        Rd            <= is_jmp_rd ? rd_data : 16'h0000;
                        state         <= EXEC;
                    end
                end
                EXEC: begin
                    pc_en         <= 1'b0;
                    BRANCH        <= 1'b0;
                    JMP           <= 1'b0;
                    flag_Rd_PC    <= 1'b0;
                    flag_label_PC <= 1'b0;
                    flag_Rm_PC    <= 1'b0;
                    disp8         <= 8'h00;
                    label11       <= 11'h000;
                    Rd            <= 16'h0000;
                    Rm            <= 16'h0000;
                    retired       <= retired + 16'd1;
                    state         <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//
// Directed bench for pc_fetch_ctrl. A phase-level model of the sequencer
// predicts every output each cycle; directed instructions carry literal
// expectations that pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        clr_n;
    logic [15:0] pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ack;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic [3:0]  rd_idx, rm_idx;
    logic [15:0] rd_data, rm_data;
    logic        pc_en, BRANCH, JMP, flag_Rd_PC, flag_label_PC, flag_Rm_PC;
    logic [7:0]  disp8;
    logic [10:0] label11;
    logic [15:0] Rd, Rm;
    logic        halted;
    logic [15:0] retired;

    pc_fetch_ctrl dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .pc            (pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .flag_z        (flag_z),
        .flag_n        (flag_n),
        .flag_c        (flag_c),
        .flag_v        (flag_v),
        .rd_idx        (rd_idx),
        .rm_idx        (rm_idx),
        .rd_data       (rd_data),
        .rm_data       (rm_data),
        .pc_en         (pc_en),
        .BRANCH        (BRANCH),
        .JMP           (JMP),
        .flag_Rd_PC    (flag_Rd_PC),
        .flag_label_PC (flag_label_PC),
        .flag_Rm_PC    (flag_Rm_PC),
        .disp8         (disp8),
        .label11       (label11),
        .Rd            (Rd),
        .Rm            (Rm),
        .halted        (halted),
        .retired       (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vectors     = 0;
    int n_miscompares = 0;
    bit sim_done      = 1'b0;

    // Compares one output group and logs any difference.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        br;
        logic        jmp;
        logic        f_rd;
        logic        f_label;
        logic        f_rm;
        logic [7:0]  disp8;
        logic [10:0] label11;
        logic [15:0] rd;
        logic [15:0] rm;
    } exec_t;

    localparam int PH_IDLE   = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_EXEC   = 3;
    localparam int PH_HALT   = 4;

    int          m_phase   = PH_IDLE;
    logic [15:0] m_ir      = 16'h0000;
    logic [15:0] m_retired = 16'h0000;
    exec_t       m_exec    = '0;

    // zncv = {Z, N, C, V}. Conditions 0..7 come in pairs (flag, !flag) over
    // Z, C, N, V; 14 is always; everything else never.
    function automatic exec_t predict(input logic [15:0] ir, input logic [3:0] zncv,
                                      input logic [15:0] rdd, input logic [15:0] rmd);
        exec_t      e;
        logic [3:0] by_pair;
        logic [3:0] cond;
        logic       taken;
        e       = '0;
        cond    = ir[11:8];
        by_pair = {zncv[0], zncv[2], zncv[1], zncv[3]};
        taken   = (cond < 4'd8) ? (by_pair[cond[2:1]] ^ cond[0]) : (cond == 4'hE);
        if (ir[15:12] == 4'hD) begin
            if (taken) begin
                e.br    = 1'b1;
                e.disp8 = ir[7:0];
            end
        end else if (ir[15:11] == 5'b11100) begin
            e.jmp     = 1'b1;
            e.f_label = 1'b1;
            e.label11 = ir[10:0];
        end else if (ir[15:7] == 9'b010001110) begin
            e.jmp  = 1'b1;
            e.f_rm = 1'b1;
            e.rm   = rmd;
        end else if (ir[15:7] == 9'b010001111) begin
            e.jmp  = 1'b1;
            e.f_rd = 1'b1;
            e.rd   = rdd;
        end
        return e;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_phase   <= PH_IDLE;
            m_ir      <= 16'h0000;
            m_retired <= 16'h0000;
            m_exec    <= '0;
        end else begin
            case (m_phase)
                PH_IDLE: m_phase <= PH_FETCH;
                PH_FETCH: if (imem_ack) begin
                    m_ir    <= imem_rdata;
                    m_phase <= PH_DECODE;
                end
                PH_DECODE: if (m_ir == 16'hFFFF) m_phase <= PH_HALT;
                else begin
                    m_exec  <= predict(m_ir, {flag_z, flag_n, flag_c, flag_v}, rd_data, rm_data);
                    m_phase <= PH_EXEC;
                end
                PH_EXEC: begin
                    m_retired <= m_retired + 16'd1;
                    m_phase   <= PH_FETCH;
                end
                default: m_phase <= PH_HALT;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        exec_t      ee;
        logic       in_fetch, in_exec;
        logic [3:0] e_rd_idx, e_rm_idx;
        #1;
        if (!sim_done) begin
            in_fetch = (m_phase == PH_FETCH);
            in_exec  = (m_phase == PH_EXEC);
            ee       = in_exec ? m_exec : '0;
            e_rd_idx = (m_phase == PH_DECODE && m_ir[15:7] == 9'b010001111) ? m_ir[6:3] : 4'h0;
            e_rm_idx = (m_phase == PH_DECODE && m_ir[15:7] == 9'b010001110) ? m_ir[6:3] : 4'h0;
            checkOutput("model_fetch", {imem_req, imem_addr},
                        {in_fetch, in_fetch ? pc : 16'h0000});
            checkOutput("model_strobes",
                        {pc_en, BRANCH, JMP, flag_Rd_PC, flag_label_PC, flag_Rm_PC, disp8, label11},
                        {in_exec, ee.br, ee.jmp, ee.f_rd, ee.f_label, ee.f_rm, ee.disp8, ee.label11});
            checkOutput("model_targets", {Rd, Rm}, {ee.rd, ee.rm});
            checkOutput("model_idx", {rd_idx, rm_idx}, {e_rd_idx, e_rm_idx});
            checkOutput("model_status", {halted, retired}, {m_phase == PH_HALT, m_retired});
        end
    end

    // ---------------- directed stimulus ----------------
    int          idle_wait;
    int          fetch_cycles;
    bit          addr_stable;
    logic [15:0] first_addr;
    logic [3:0]  dec_rd_idx, dec_rm_idx;

    // Runs one instruction through FETCH (with 'delay' ack-low cycles) and
    // DECODE, returning on the falling edge inside EXEC (or HALT).
    task applyStimulus(input logic [15:0] ir, input logic [3:0] zncv,
                       input logic [15:0] rdd, input logic [15:0] rmd, input int delay);
        idle_wait = 0;
        @(negedge clk);
        while (imem_req !== 1'b1 && idle_wait < 20) begin
            idle_wait++;
            @(negedge clk);
        end
        if (imem_req !== 1'b1) begin
            checkOutput("fetch_timeout", {127'h0, imem_req}, 128'h1);
            return;
        end
        first_addr   = imem_addr;
        addr_stable  = 1'b1;
        fetch_cycles = 0;
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 16'hFFFF;
            if (imem_req === 1'b1) fetch_cycles++;
            if (imem_addr !== first_addr) addr_stable = 1'b0;
            @(negedge clk);
        end
        if (imem_req === 1'b1) fetch_cycles++;
        if (imem_addr !== first_addr) addr_stable = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = ir;
        {flag_z, flag_n, flag_c, flag_v} = zncv;
        rd_data = rdd;
        rm_data = rmd;
        @(negedge clk);
        dec_rd_idx = rd_idx;
        dec_rm_idx = rm_idx;
        imem_rdata = ~ir;
        @(negedge clk);
        {flag_z, flag_n, flag_c, flag_v} = ~zncv;
        rd_data  = ~rdd;
        rm_data  = ~rmd;
        imem_ack = 1'b0;
        pc       = pc + 16'd3;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr_n      = 1'b0;
        pc         = 16'h0100;
        imem_rdata = 16'h0000;
        imem_ack   = 1'b0;
        {flag_z, flag_n, flag_c, flag_v} = 4'h0;
        rd_data    = 16'h0000;
        rm_data    = 16'h0000;

        // Reset: everything zero, then one IDLE cycle before FETCH.
        #50;
        checkOutput("reset_all_zero",
                    {imem_req, imem_addr, pc_en, BRANCH, JMP, flag_Rd_PC, flag_label_PC, flag_Rm_PC,
                     disp8, label11, Rd, Rm, halted, retired, rd_idx, rm_idx}, 128'h0);
        #50;
        clr_n = 1'b1;
        #1;
        checkOutput("idle_no_req", {127'h0, imem_req}, 128'h0);

        // Conditional branch EQ, Z=1 -> taken.
        applyStimulus(16'hD005, 4'b1000, 16'h0, 16'h0, 0);
        checkOutput("first_fetch_after_idle", idle_wait, 0);
        checkOutput("first_fetch_addr", first_addr, 16'h0100);
        checkOutput("d005_z1", {pc_en, BRANCH, JMP, disp8}, {1'b1, 1'b1, 1'b0, 8'h05});
        checkOutput("d005_z1_retired", retired, 16'd0);

        // Conditional branch EQ, Z=0 -> not taken.
        applyStimulus(16'hD005, 4'b0000, 16'h0, 16'h0, 0);
        checkOutput("d005_z0", {pc_en, BRANCH, JMP, disp8}, {1'b1, 1'b0, 1'b0, 8'h00});
        checkOutput("zero_wait_fetch", fetch_cycles, 1);

        // Label jump.
        applyStimulus(16'hE00F, 4'b0000, 16'h0, 16'h0, 0);
        checkOutput("e00f", {JMP, flag_label_PC, flag_Rd_PC, flag_Rm_PC, label11},
                    {1'b1, 1'b1, 1'b0, 1'b0, 11'd15});

        // Register jump via Rm.
        applyStimulus(16'h4718, 4'b0000, 16'd7, 16'd50, 0);
        checkOutput("4718_idx", {dec_rd_idx, dec_rm_idx}, {4'd0, 4'd3});
        checkOutput("4718", {JMP, flag_Rm_PC, flag_Rd_PC, Rm, Rd},
                    {1'b1, 1'b1, 1'b0, 16'd50, 16'd0});

        // Register jump via Rd.
        applyStimulus(16'h4790, 4'b0000, 16'd20, 16'd9, 0);
        checkOutput("4790_idx", {dec_rd_idx, dec_rm_idx}, {4'd2, 4'd0});
        checkOutput("4790", {JMP, flag_Rd_PC, flag_Rm_PC, Rd, Rm},
                    {1'b1, 1'b1, 1'b0, 16'd20, 16'd0});

        // Non-control word with three wait states.
        applyStimulus(16'h1234, 4'b1111, 16'h0, 16'h0, 3);
        checkOutput("wait_fetch_cycles", fetch_cycles, 4);
        checkOutput("wait_addr_stable", {127'h0, addr_stable}, 128'h1);
        checkOutput("wait_exec", {pc_en, BRANCH, JMP}, {1'b1, 1'b0, 1'b0});
        checkOutput("wait_retired", retired, 16'd5);

        // Every condition code under a varying flag pattern.
        for (int c = 0; c < 16; c++) begin
            logic [3:0] cc;
            cc = 4'(c);
            applyStimulus({4'hD, cc, 8'h80 + 8'(c)}, 4'(c * 7 + 3), 16'h0, 16'h0, c % 2);
        end

        // Always / never conditions against opposite flag settings.
        applyStimulus(16'hDE7F, 4'b0000, 16'h0, 16'h0, 0);
        checkOutput("cond_al", {BRANCH, disp8}, {1'b1, 8'h7F});
        applyStimulus(16'hD87F, 4'b1111, 16'h0, 16'h0, 0);
        checkOutput("cond_never", {pc_en, BRANCH, disp8}, {1'b1, 1'b0, 8'h00});
        applyStimulus(16'hD2A0, 4'b0010, 16'h0, 16'h0, 0);
        checkOutput("cond_cs", {BRANCH, disp8}, {1'b1, 8'hA0});

        // Reset pulse in the middle of EXEC, then a late ack through IDLE.
        applyStimulus(16'hE123, 4'b0000, 16'h0, 16'h0, 0);
        checkOutput("abort_in_exec", {JMP, label11}, {1'b1, 11'h123});
        clr_n = 1'b0;
        #1;
        checkOutput("abort_all_zero",
                    {imem_req, imem_addr, pc_en, BRANCH, JMP, flag_Rd_PC, flag_label_PC, flag_Rm_PC,
                     disp8, label11, Rd, Rm, halted, retired, rd_idx, rm_idx}, 128'h0);
        imem_ack   = 1'b1;
        imem_rdata = 16'hFFFF;
        @(negedge clk);
        clr_n = 1'b1;
        applyStimulus(16'h0001, 4'b0000, 16'h0, 16'h0, 1);
        checkOutput("after_abort_idle", idle_wait, 0);
        checkOutput("after_abort_exec", {pc_en, halted, retired}, {1'b1, 1'b0, 16'd0});

        // HALT: parked with pc_en low while ack toggles.
        applyStimulus(16'hFFFF, 4'b0000, 16'h0, 16'h0, 0);
        checkOutput("halt_entry", {halted, pc_en, retired}, {1'b1, 1'b0, 16'd1});
        for (int i = 0; i < 10; i++) begin
            imem_ack = i[0];
            @(negedge clk);
            checkOutput("halt_hold", {halted, pc_en, imem_req, BRANCH, JMP},
                        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        end

        @(negedge clk);
        #2;
        sim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
